rob_entry_table: RTL and testbench
==================================

ROB_ENTRY_TABLE -- requirements
Module: rob_entry_table

Interface
- REQ-001 The block SHALL take constants from defines.v: ROB_Entry_Width=3 (8 entries), Data_Width=32, Addr_Width=32, Reg_Width=5, ROB_Bus_Width=2+Addr_Width+Data_Width+1=67.
- REQ-002 clk  in  1  single clock; all state changes on rising edge.
- REQ-003 rst  in  1  reset, asynchronous assert, active-low.
- REQ-004 rob_write  in  1  allocate request from Decoder.
- REQ-005 rob_bus  in  67  {type[66:65], dest[64:33], data[32:1], ready[0]}; type 1=Branch, 2=Store, 3=Normal_Op.
- REQ-006 rob_stall  out  1  table full.
- REQ-007 rob_rd_lock  out  3  tag of the entry the next allocation receives (tail index).
- REQ-008 rob_check_rs1/rs2  in  1  operand lookup enables.
- REQ-009 rob_value_entry1/2  in  3  tags to look up.
- REQ-010 rob_value_enable1/2  out  1  looked-up value available.
- REQ-011 rob_value1/2  out  32  looked-up value.
- REQ-012 cdb_valid  in  1, cdb_tag  in  3, cdb_data  in  32  ALU result broadcast.
- REQ-013 commit_write  out  1, commit_rd  out  5, commit_data  out  32, commit_tag  out  3  retirement to RegFile (RegFile clears lock only if lock==commit_tag).

Function
- REQ-014 Per entry state SHALL be: valid, ready, type, dest, data.
- REQ-015 head, tail (3-bit, wrap 7->0) and count (4-bit, 0..8) SHALL track occupancy.
- REQ-016 rob_stall SHALL equal (count==8), combinational.
- REQ-017 rob_write while rob_stall SHALL be ignored; otherwise the entry at tail is loaded from rob_bus, valid set, tail increments at that edge.
- REQ-018 rob_rd_lock SHALL equal tail, combinational, so the Decoder's same-cycle tag matches the allocated entry.
- REQ-019 On cdb_valid with valid[cdb_tag]=1 the entry SHALL capture cdb_data and set ready at the edge; cdb on an invalid entry SHALL be ignored.
- REQ-020 Lookup (per port, combinational): enable=1 and value=cdb_data if check && cdb_valid && cdb_tag==entry; else enable=valid&&ready and value=data of entry; enable=0, value=0 when check=0.
- REQ-021 Commit: when valid[head]&&ready[head], one entry SHALL retire per cycle: head increments, valid cleared at the edge.
- REQ-022 commit_write SHALL be combinational = valid[head]&&ready[head]&&type==Normal_Op; commit_rd=dest[4:0], commit_data=data, commit_tag=head; Branch/Store retire with commit_write=0.
- REQ-023 Latency: CDB at edge N sets ready; commit_write high during cycle N+1 (if at head); head advances at edge N+1.
- REQ-024 Simultaneous allocate and retire SHALL leave count unchanged; when full, retire frees a slot for the following cycle only (stall not relaxed same cycle).
- REQ-025 CDB and retire of the same entry in one cycle cannot occur (retire needs ready already set); CDB write to the entry being allocated the same cycle SHALL lose to allocation.
- REQ-026 An entry allocated with ready=1 SHALL be eligible to retire the next cycle.

Reset
- REQ-027 On rst low: head=tail=count=0, all valid/ready=0; outputs: rob_stall=0, rob_rd_lock=0, commit_write=0, value_enables=0; data/dest arrays need not reset.
- REQ-028 Reset mid-operation SHALL discard all entries immediately; first allocation after release gets tag 0.

Structure
- REQ-029 Type codes (Branch/Store/Normal_Op), widths and bus layout SHALL live in defines.v, shared with the Decoder.
- REQ-030 One sub-module rob_lookup_port (REQ-020 logic), instantiated twice.

Verification
- REQ-031 Reset, allocate Normal_Op rd=5 ready=0 -> rob_rd_lock 0 then 1, count=1, commit_write=0.
- REQ-032 cdb_valid tag=0 data=0x1234 -> next cycle commit_write=1, commit_rd=5, commit_data=0x1234, commit_tag=0; count returns 0.
- REQ-033 Allocate 8 without CDB -> rob_stall=1; 9th rob_write ignored, tail stays 0.
- REQ-034 Full, CDB tag 0, then rob_write held -> retire one cycle, allocation accepted following cycle with rob_rd_lock=0 (wrap).
- REQ-035 Lookup tag 3 same cycle as cdb tag 3 data 0xBEEF -> rob_value_enable1=1, rob_value1=0xBEEF; tag 4 unready -> enable2=0.
- REQ-036 Branch entry at head made ready -> retires, commit_write stays 0; rst low mid-fill -> count=0, rob_stall=0 asynchronously.

Source files
------------

// File: rtl/rob_entry_table_pkg.sv
// Shared ROB constants, entry type codes and the allocate bus layout.
// Imported by the ROB table, its lookup port and the Decoder.
package rob_entry_table_pkg;

  localparam int ROB_ENTRY_WIDTH = 3;
  localparam int ROB_DEPTH       = 1 << ROB_ENTRY_WIDTH;
  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 32;
  localparam int REG_WIDTH       = 5;
  localparam int ROB_BUS_WIDTH   = 2 + ADDR_WIDTH + DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ROB_NONE   = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_NORMAL = 2'd3
  } rob_type_e;

  // {type[66:65], dest[64:33], data[32:1], ready[0]}
  typedef struct packed {
    rob_type_e             typ;
    logic [ADDR_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
  } rob_bus_t;

endpackage

// File: rtl/rob_entry_table_lookup_port.sv
// One ROB operand lookup port; CDB bypass has priority over the table.
// Ports: i_check/i_entry request, i_cdb_* broadcast, i_valid/i_ready/i_data of entry, o_enable/o_value.
module rob_lookup_port
  import rob_entry_table_pkg::*;
(
  input  logic                       i_check,
  input  logic [ROB_ENTRY_WIDTH-1:0] i_entry,
  input  logic                       i_cdb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]      i_cdb_data,
  input  logic                       i_valid,
  input  logic                       i_ready,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_enable,
  output logic [DATA_WIDTH-1:0]      o_value
);

  logic w_bypass;

  assign w_bypass = i_cdb_valid && (i_cdb_tag == i_entry);

  always_comb begin
    o_enable = 1'b0;
    o_value  = '0;
    if (i_check) begin
      if (w_bypass) begin
        o_enable = 1'b1;
        o_value  = i_cdb_data;
      end else begin
        o_enable = i_valid && i_ready;
        o_value  = i_data;
      end
    end
  end

endmodule

// File: rtl/rob_entry_table.sv
// 8-entry reorder buffer: in-order allocate, CDB completion, in-order retire.
// Ports: rob_write/rob_bus alloc, rob_stall/rob_rd_lock, two lookups, cdb_*, commit_*.
module rob_entry_table
  import rob_entry_table_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rob_write,
  input  logic [ROB_BUS_WIDTH-1:0]   rob_bus,
  output logic                       rob_stall,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_rd_lock,
  input  logic                       rob_check_rs1,
  input  logic                       rob_check_rs2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_value_entry1,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_value_entry2,
  output logic                       rob_value_enable1,
  output logic                       rob_value_enable2,
  output logic [DATA_WIDTH-1:0]      rob_value1,
  output logic [DATA_WIDTH-1:0]      rob_value2,
  input  logic                       cdb_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0] cdb_tag,
  input  logic [DATA_WIDTH-1:0]      cdb_data,
  output logic                       commit_write,
  output logic [REG_WIDTH-1:0]       commit_rd,
  output logic [DATA_WIDTH-1:0]      commit_data,
  output logic [ROB_ENTRY_WIDTH-1:0] commit_tag
);

  logic [ROB_DEPTH-1:0]       r_valid;
  logic [ROB_DEPTH-1:0]       r_ready;
  rob_type_e                  r_type [ROB_DEPTH];
  logic [REG_WIDTH-1:0]       r_dest [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]      r_data [ROB_DEPTH];
  logic [ROB_ENTRY_WIDTH-1:0] r_head;
  logic [ROB_ENTRY_WIDTH-1:0] r_tail;
  logic [ROB_ENTRY_WIDTH:0]   r_count;

  rob_bus_t w_bus;
  logic     w_full;
  logic     w_alloc;
  logic     w_retire;
  logic     w_cdb_hit;
  logic     w_unused_dest;

  assign w_bus     = rob_bus_t'(rob_bus);
  assign w_full    = (r_count == ROB_DEPTH[ROB_ENTRY_WIDTH:0]);
  assign w_alloc   = rob_write && !w_full;
  assign w_retire  = r_valid[r_head] && r_ready[r_head];
  assign w_cdb_hit = cdb_valid && r_valid[cdb_tag];

  // Only the architectural register index of dest is retired.
  assign w_unused_dest = ^w_bus.dest[ADDR_WIDTH-1:REG_WIDTH];

  assign rob_stall    = w_full;
  assign rob_rd_lock  = r_tail;
  assign commit_write = w_retire && (r_type[r_head] == ROB_NORMAL);
  assign commit_rd    = r_dest[r_head];
  assign commit_data  = r_data[r_head];
  assign commit_tag   = r_head;

  // Later assignments win: retire over a stale CDB on the head,
  // allocation over a CDB aimed at the slot being allocated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_ready <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_cdb_hit) begin
        r_ready[cdb_tag] <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + 3'd1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= w_bus.ready;
        r_tail          <= r_tail + 3'd1;
      end
      r_count <= r_count
               + {{ROB_ENTRY_WIDTH{1'b0}}, w_alloc}
               - {{ROB_ENTRY_WIDTH{1'b0}}, w_retire};
    end
  end

  // Payload needs no reset; it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_cdb_hit) begin
      r_data[cdb_tag] <= cdb_data;
    end
    if (w_alloc) begin
      r_type[r_tail] <= w_bus.typ;
      r_dest[r_tail] <= w_bus.dest[REG_WIDTH-1:0];
      r_data[r_tail] <= w_bus.data;
    end
  end

  rob_lookup_port u_lookup1 (
    .i_check     (rob_check_rs1),
    .i_entry     (rob_value_entry1),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_data  (cdb_data),
    .i_valid     (r_valid[rob_value_entry1]),
    .i_ready     (r_ready[rob_value_entry1]),
    .i_data      (r_data[rob_value_entry1]),
    .o_enable    (rob_value_enable1),
    .o_value     (rob_value1)
  );

  rob_lookup_port u_lookup2 (
    .i_check     (rob_check_rs2),
    .i_entry     (rob_value_entry2),
    .i_cdb_valid (cdb_valid),
    .i_cdb_tag   (cdb_tag),
    .i_cdb_data  (cdb_data),
    .i_valid     (r_valid[rob_value_entry2]),
    .i_ready     (r_ready[rob_value_entry2]),
    .i_data      (r_data[rob_value_entry2]),
    .o_enable    (rob_value_enable2),
    .o_value     (rob_value2)
  );

endmodule

// File: tb/tb_rob_entry_table.sv
// Directed and randomized checks of rob_entry_table.
// Random phase compares against a queue-based reorder-buffer model.
module tb_rob_entry_table;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rob_write = 1'b0;
  logic [66:0] rob_bus = '0;
  logic        rob_stall;
  logic [2:0]  rob_rd_lock;
  logic        rob_check_rs1 = 1'b0;
  logic        rob_check_rs2 = 1'b0;
  logic [2:0]  rob_value_entry1 = '0;
  logic [2:0]  rob_value_entry2 = '0;
  logic        rob_value_enable1;
  logic        rob_value_enable2;
  logic [31:0] rob_value1;
  logic [31:0] rob_value2;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        commit_write;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [2:0]  commit_tag;

  int checks = 0;
  int errors = 0;

  rob_entry_table dut (
    .clk               (clk),
    .rst               (rst),
    .rob_write         (rob_write),
    .rob_bus           (rob_bus),
    .rob_stall         (rob_stall),
    .rob_rd_lock       (rob_rd_lock),
    .rob_check_rs1     (rob_check_rs1),
    .rob_check_rs2     (rob_check_rs2),
    .rob_value_entry1  (rob_value_entry1),
    .rob_value_entry2  (rob_value_entry2),
    .rob_value_enable1 (rob_value_enable1),
    .rob_value_enable2 (rob_value_enable2),
    .rob_value1        (rob_value1),
    .rob_value2        (rob_value2),
    .cdb_valid         (cdb_valid),
    .cdb_tag           (cdb_tag),
    .cdb_data          (cdb_data),
    .commit_write      (commit_write),
    .commit_rd         (commit_rd),
    .commit_data       (commit_data),
    .commit_tag        (commit_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [1:0]  typ;
    logic [4:0]  dest;
    logic [31:0] data;
    bit          rdy;
  } ent_t;

  ent_t q[$];
  int   m_next;

  function automatic int m_find(input int tag);
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rob_write     = 1'b0;
    rob_bus       = '0;
    rob_check_rs1 = 1'b0;
    rob_check_rs2 = 1'b0;
    cdb_valid     = 1'b0;
    cdb_tag       = '0;
    cdb_data      = '0;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_bus(input logic [1:0] t, input logic [31:0] d,
                         input logic [31:0] v, input logic r);
    rob_bus = {t, d, v, r};
  endtask

  task automatic test_reset;
    do_reset();
    rob_check_rs1 = 1'b1;
    rob_check_rs2 = 1'b1;
    rob_value_entry1 = 3'd0;
    rob_value_entry2 = 3'd5;
    #1;
    checks++;
    if (rob_stall !== 1'b0 || rob_rd_lock !== 3'd0 || commit_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got stall=%b lock=%0d cw=%b exp 0 0 0",
               rob_stall, rob_rd_lock, commit_write);
    end
    checks++;
    if (rob_value_enable1 !== 1'b0 || rob_value_enable2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_enables got %b%b exp 00",
               rob_value_enable1, rob_value_enable2);
    end
    idle();
  endtask

  task automatic test_alloc_commit;
    do_reset();
    rob_write = 1'b1;
    set_bus(2'd3, 32'd5, 32'd0, 1'b0);
    #1;
    checks++;
    if (rob_rd_lock !== 3'd0) begin
      errors++;
      $display("FAIL alloc_lock0 got %0d exp 0", rob_rd_lock);
    end
    tick();
    rob_write = 1'b0;
    #1;
    checks++;
    if (rob_rd_lock !== 3'd1 || commit_write !== 1'b0) begin
      errors++;
      $display("FAIL alloc_lock1 got lock=%0d cw=%b exp 1 0",
               rob_rd_lock, commit_write);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 3'd0;
    cdb_data  = 32'h1234;
    #1;
    checks++;
    if (commit_write !== 1'b0) begin
      errors++;
      $display("FAIL cdb_same_cycle_cw got %b exp 0", commit_write);
    end
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (commit_write !== 1'b1 || commit_rd !== 5'd5 ||
        commit_data !== 32'h1234 || commit_tag !== 3'd0) begin
      errors++;
      $display("FAIL commit got cw=%b rd=%0d data=%h tag=%0d exp 1 5 1234 0",
               commit_write, commit_rd, commit_data, commit_tag);
    end
    tick();
    #1;
    checks++;
    if (commit_write !== 1'b0 || commit_tag !== 3'd1 || rob_stall !== 1'b0) begin
      errors++;
      $display("FAIL after_commit got cw=%b tag=%0d stall=%b exp 0 1 0",
               commit_write, commit_tag, rob_stall);
    end
  endtask

  task automatic test_full;
    do_reset();
    rob_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_bus(2'd3, 32'(i), 32'(i * 3), 1'b0);
      tick();
    end
    #1;
    checks++;
    if (rob_stall !== 1'b1 || rob_rd_lock !== 3'd0) begin
      errors++;
      $display("FAIL full got stall=%b lock=%0d exp 1 0", rob_stall, rob_rd_lock);
    end
    tick();
    #1;
    checks++;
    if (rob_stall !== 1'b1 || rob_rd_lock !== 3'd0) begin
      errors++;
      $display("FAIL ninth_ignored got stall=%b lock=%0d exp 1 0",
               rob_stall, rob_rd_lock);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 3'd0;
    cdb_data  = 32'hAA;
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (commit_write !== 1'b1 || commit_tag !== 3'd0 || rob_stall !== 1'b1) begin
      errors++;
      $display("FAIL full_retire got cw=%b tag=%0d stall=%b exp 1 0 1",
               commit_write, commit_tag, rob_stall);
    end
    tick();
    #1;
    checks++;
    if (rob_stall !== 1'b0 || rob_rd_lock !== 3'd0 || commit_tag !== 3'd1) begin
      errors++;
      $display("FAIL freed_slot got stall=%b lock=%0d head=%0d exp 0 0 1",
               rob_stall, rob_rd_lock, commit_tag);
    end
    tick();
    rob_write = 1'b0;
    #1;
    checks++;
    if (rob_stall !== 1'b1 || rob_rd_lock !== 3'd1) begin
      errors++;
      $display("FAIL wrap_alloc got stall=%b lock=%0d exp 1 1",
               rob_stall, rob_rd_lock);
    end
  endtask

  task automatic test_lookup;
    do_reset();
    rob_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_bus(2'd3, 32'(i + 1), 32'hDEAD0000 + 32'(i), 1'b0);
      tick();
    end
    rob_write = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd3;
    cdb_data  = 32'hBEEF;
    rob_check_rs1 = 1'b1;
    rob_value_entry1 = 3'd3;
    rob_check_rs2 = 1'b1;
    rob_value_entry2 = 3'd4;
    #1;
    checks++;
    if (rob_value_enable1 !== 1'b1 || rob_value1 !== 32'hBEEF) begin
      errors++;
      $display("FAIL lookup_bypass got en=%b val=%h exp 1 beef",
               rob_value_enable1, rob_value1);
    end
    checks++;
    if (rob_value_enable2 !== 1'b0) begin
      errors++;
      $display("FAIL lookup_unready got en=%b exp 0", rob_value_enable2);
    end
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (rob_value_enable1 !== 1'b1 || rob_value1 !== 32'hBEEF) begin
      errors++;
      $display("FAIL lookup_stored got en=%b val=%h exp 1 beef",
               rob_value_enable1, rob_value1);
    end
    rob_check_rs1 = 1'b0;
    #1;
    checks++;
    if (rob_value_enable1 !== 1'b0 || rob_value1 !== 32'd0) begin
      errors++;
      $display("FAIL lookup_off got en=%b val=%h exp 0 0",
               rob_value_enable1, rob_value1);
    end
    idle();
  endtask

  task automatic test_branch_reset;
    do_reset();
    rob_write = 1'b1;
    set_bus(2'd1, 32'd7, 32'd0, 1'b0);
    tick();
    rob_write = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 3'd0;
    cdb_data  = 32'h55;
    tick();
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (commit_write !== 1'b0 || commit_tag !== 3'd0) begin
      errors++;
      $display("FAIL branch_retire got cw=%b tag=%0d exp 0 0",
               commit_write, commit_tag);
    end
    tick();
    #1;
    checks++;
    if (commit_tag !== 3'd1) begin
      errors++;
      $display("FAIL branch_head_adv got %0d exp 1", commit_tag);
    end
    rob_write = 1'b1;
    set_bus(2'd3, 32'd9, 32'h77, 1'b1);
    tick();
    rob_write = 1'b0;
    #1;
    checks++;
    if (commit_write !== 1'b1 || commit_rd !== 5'd9 ||
        commit_data !== 32'h77 || commit_tag !== 3'd1) begin
      errors++;
      $display("FAIL ready_alloc got cw=%b rd=%0d data=%h tag=%0d exp 1 9 77 1",
               commit_write, commit_rd, commit_data, commit_tag);
    end
    tick();
    rob_write = 1'b1;
    set_bus(2'd2, 32'd1, 32'd1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    rob_write = 1'b0;
    #1;
    checks++;
    if (rob_stall !== 1'b1) begin
      errors++;
      $display("FAIL prefill_full got %b exp 1", rob_stall);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (rob_stall !== 1'b0 || rob_rd_lock !== 3'd0 || commit_write !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got stall=%b lock=%0d cw=%b exp 0 0 0",
               rob_stall, rob_rd_lock, commit_write);
    end
    tick();
    rst = 1'b1;
    rob_write = 1'b1;
    set_bus(2'd3, 32'd2, 32'd2, 1'b0);
    #1;
    checks++;
    if (rob_rd_lock !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_tag got %0d exp 0", rob_rd_lock);
    end
    tick();
    rob_write = 1'b0;
    #1;
    checks++;
    if (rob_rd_lock !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_adv got %0d exp 1", rob_rd_lock);
    end
  endtask

  task automatic test_random;
    logic [1:0]  t;
    bit          e_stall, e_cw, e_en;
    logic [31:0] e_val;
    int          e_head, idx;
    bit          ret, alloc;
    do_reset();
    q.delete();
    m_next = 0;
    repeat (400) begin
      rob_write = ($urandom_range(0, 9) < 6);
      t = 2'($urandom_range(1, 3));
      set_bus(t, $urandom, $urandom, ($urandom_range(0, 3) == 0));
      cdb_valid = $urandom_range(0, 1);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        cdb_tag = 3'(q[$urandom_range(0, q.size() - 1)].tag);
      else
        cdb_tag = 3'($urandom_range(0, 7));
      cdb_data = $urandom;
      rob_check_rs1 = $urandom_range(0, 1);
      rob_check_rs2 = $urandom_range(0, 1);
      rob_value_entry1 = 3'($urandom_range(0, 7));
      rob_value_entry2 = 3'($urandom_range(0, 7));
      #2;
      e_stall = (q.size() == 8);
      e_cw = (q.size() > 0) && q[0].rdy && (q[0].typ == 2'd3);
      e_head = (q.size() > 0) ? q[0].tag : m_next;
      checks++;
      if (rob_stall !== e_stall || rob_rd_lock !== 3'(m_next)) begin
        errors++;
        $display("FAIL rnd_alloc got stall=%b lock=%0d exp %b %0d",
                 rob_stall, rob_rd_lock, e_stall, m_next);
      end
      checks++;
      if (commit_write !== e_cw || commit_tag !== 3'(e_head)) begin
        errors++;
        $display("FAIL rnd_commit got cw=%b tag=%0d exp %b %0d",
                 commit_write, commit_tag, e_cw, e_head);
      end
      if (e_cw) begin
        checks++;
        if (commit_rd !== q[0].dest || commit_data !== q[0].data) begin
          errors++;
          $display("FAIL rnd_commit_data got rd=%0d d=%h exp %0d %h",
                   commit_rd, commit_data, q[0].dest, q[0].data);
        end
      end
      e_en = 1'b0;
      e_val = '0;
      if (rob_check_rs1) begin
        idx = m_find(int'(rob_value_entry1));
        if (cdb_valid && cdb_tag == rob_value_entry1) begin
          e_en = 1'b1;
          e_val = cdb_data;
        end else if (idx >= 0 && q[idx].rdy) begin
          e_en = 1'b1;
          e_val = q[idx].data;
        end
      end
      checks++;
      if (rob_value_enable1 !== e_en ||
          ((e_en || !rob_check_rs1) && rob_value1 !== e_val)) begin
        errors++;
        $display("FAIL rnd_lookup1 got en=%b v=%h exp %b %h",
                 rob_value_enable1, rob_value1, e_en, e_val);
      end
      e_en = 1'b0;
      e_val = '0;
      if (rob_check_rs2) begin
        idx = m_find(int'(rob_value_entry2));
        if (cdb_valid && cdb_tag == rob_value_entry2) begin
          e_en = 1'b1;
          e_val = cdb_data;
        end else if (idx >= 0 && q[idx].rdy) begin
          e_en = 1'b1;
          e_val = q[idx].data;
        end
      end
      checks++;
      if (rob_value_enable2 !== e_en ||
          ((e_en || !rob_check_rs2) && rob_value2 !== e_val)) begin
        errors++;
        $display("FAIL rnd_lookup2 got en=%b v=%h exp %b %h",
                 rob_value_enable2, rob_value2, e_en, e_val);
      end
      @(posedge clk);
      ret = (q.size() > 0) && q[0].rdy;
      alloc = rob_write && (q.size() < 8);
      if (cdb_valid) begin
        idx = m_find(int'(cdb_tag));
        if (idx >= 0) begin
          q[idx].rdy = 1'b1;
          q[idx].data = cdb_data;
        end
      end
      if (ret) void'(q.pop_front());
      if (alloc) begin
        q.push_back('{m_next, rob_bus[66:65], rob_bus[37:33],
                      rob_bus[32:1], rob_bus[0]});
        m_next = (m_next + 1) % 8;
      end
      #1;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc_commit();
    test_full();
    test_lookup();
    test_branch_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
